// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a first-word-fall-through FIFO with valid/ready drain.
// Optional build macro UART_RX_MAJORITY_EN: 2-of-3 majority vote around each sample point.
module uart_rx_fifo #(
  parameter int sysclk_frequency = 1250,
  parameter int baud             = 115200,
  parameter int fifo_depth_log2  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rxd,
  output logic [7:0]               q,
  output logic                     q_valid,
  input  logic                     q_ready,
  output logic [fifo_depth_log2:0] fill,
  output logic                     framing_err,
  output logic                     overrun,
  input  logic                     overrun_clr
);

  localparam int CPB   = (sysclk_frequency * 100000 + baud / 2) / baud;
  localparam int HALF  = CPB / 2;
  localparam int CW    = (CPB > 2) ? $clog2(CPB) : 1;
  localparam int AW    = fifo_depth_log2;
  localparam int DEPTH = 1 << AW;

  localparam logic [CW-1:0] CntBit = CW'(CPB - 1);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [CW-1:0] CntStart = CW'(HALF);
`else
  localparam logic [CW-1:0] CntStart = CW'(HALF - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bitIdx_q, bitIdx_d;
  logic [7:0]    shift_q, shift_d;
  logic          push_q, push_d;
  logic          framingErr_q, framingErr_d;
  logic          sync1_q, rxs_q;
  logic          tick, bitVal;

  logic [7:0]    mem [DEPTH];
  logic [AW:0]   wrPtr_q, rdPtr_q;
  logic          overrun_q;
  logic          full, pop, wrEn, ovSet;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= rxd;
      rxs_q   <= sync1_q;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // The decision is taken one cycle after nominal, so the history holds nominal-1 and nominal.
  logic rxsD1_q, rxsD2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rxsD1_q <= 1'b1;
      rxsD2_q <= 1'b1;
    end else begin
      rxsD1_q <= rxs_q;
      rxsD2_q <= rxsD1_q;
    end
  end

  assign bitVal = (rxsD2_q & rxsD1_q) | (rxsD2_q & rxs_q) | (rxsD1_q & rxs_q);
`else
  assign bitVal = rxs_q;
`endif

  assign tick = (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bitIdx_q     <= '0;
      shift_q      <= '0;
      push_q       <= 1'b0;
      framingErr_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bitIdx_q     <= bitIdx_d;
      shift_q      <= shift_d;
      push_q       <= push_d;
      framingErr_q <= framingErr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = tick ? cnt_q : cnt_q - CW'(1);
    bitIdx_d     = bitIdx_q;
    shift_d      = shift_q;
    push_d       = 1'b0;
    framingErr_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rxs_q) begin
          state_d = S_START;
          cnt_d   = CntStart;
        end
      end
      S_START: begin
        if (tick) begin
          cnt_d    = CntBit;
          bitIdx_d = '0;
          state_d  = bitVal ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_d  = {bitVal, shift_q[7:1]};
          cnt_d    = CntBit;
          bitIdx_d = bitIdx_q + 3'd1;
          if (bitIdx_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (bitVal) begin
            push_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            framingErr_d = 1'b1;
            state_d      = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (rxs_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A push into a full FIFO still lands if a pop frees a slot on the same edge.
  assign fill    = wrPtr_q - rdPtr_q;
  assign q_valid = (fill != '0);
  assign full    = (fill == (AW + 1)'(DEPTH));
  assign pop     = q_valid & q_ready;
  assign wrEn    = push_q & (~full | pop);
  assign ovSet   = push_q & full & ~pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (wrEn) wrPtr_q <= wrPtr_q + (AW + 1)'(1);
      if (pop)  rdPtr_q <= rdPtr_q + (AW + 1)'(1);
      overrun_q <= ovSet | (overrun_q & ~overrun_clr);
    end
  end

  always_ff @(posedge clk) begin
    if (wrEn) mem[wrPtr_q[AW-1:0]] <= shift_q;
  end

  assign q           = q_valid ? mem[rdPtr_q[AW-1:0]] : 8'h00;
  assign framing_err = framingErr_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: table of frames plus hand-written corner sequences,
// with a byte scoreboard popped on every consumer handshake.
module tb_uart_rx_fifo;

  localparam int SYSCLK = 16;
  localparam int BAUD   = 100000;
  localparam int CPB    = (SYSCLK * 100000 + BAUD / 2) / BAUD;
  localparam int HALF   = CPB / 2;
  localparam int AW     = 4;
  localparam int DEPTH  = 1 << AW;
`ifdef UART_RX_MAJORITY_EN
  localparam int PUSH_EDGE = HALF + 5 + 9 * CPB;
`else
  localparam int PUSH_EDGE = HALF + 4 + 9 * CPB;
`endif

  logic          clk;
  logic          reset;
  logic          rxd;
  logic [7:0]    q;
  logic          q_valid;
  logic          q_ready;
  logic [AW:0]   fill;
  logic          framing_err;
  logic          overrun;
  logic          overrun_clr;

  int            passCount = 0;
  int            checkCount = 0;
  int            feCount = 0;
  logic [7:0]    sb[$];

  typedef struct {
    logic [7:0] data;
    logic       stopBit;
    int         expFill;
    int         expFe;
  } vec_t;

  vec_t vecs[7];

  uart_rx_fifo #(
    .sysclk_frequency(SYSCLK),
    .baud(BAUD),
    .fifo_depth_log2(AW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rxd(rxd),
    .q(q),
    .q_valid(q_valid),
    .q_ready(q_ready),
    .fill(fill),
    .framing_err(framing_err),
    .overrun(overrun),
    .overrun_clr(overrun_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every cycle framing_err is high so pulse width and count are both observable.
  always @(negedge clk) begin
    if (framing_err === 1'b1) feCount++;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    else
      passCount++;
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input int holdLow);
    rxd = 1'b0;
    waitCycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = data[i];
      waitCycles(CPB);
    end
    rxd = stopBit;
    waitCycles(CPB);
    if (!stopBit) waitCycles(holdLow);
    rxd = 1'b1;
    waitCycles(4);
  endtask

  // Drain at one pop per cycle, comparing each head byte against the scoreboard.
  task automatic drainAll(input string name);
    logic [7:0] exp;
    int guard = 0;
    q_ready = 1'b1;
    while (q_valid === 1'b1 && guard < DEPTH + 2) begin
      if (sb.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL %s_extra: got byte 0x%0h, expected none", name, q);
      end else begin
        exp = sb.pop_front();
        checkOutput(name, {24'h0, q}, {24'h0, exp});
      end
      waitCycles(1);
      guard++;
    end
    q_ready = 1'b0;
    checkOutput({name, "_left"}, sb.size(), 0);
    checkOutput({name, "_fill"}, {27'h0, fill}, 0);
  endtask

  initial begin
    int         feBefore;
    logic [7:0] expHead;

    vecs[0] = '{8'hA5, 1'b1, 1, 0};
    vecs[1] = '{8'h00, 1'b1, 1, 0};
    vecs[2] = '{8'hFF, 1'b1, 1, 0};
    vecs[3] = '{8'h55, 1'b1, 1, 0};
    vecs[4] = '{8'h80, 1'b1, 1, 0};
    vecs[5] = '{8'h3C, 1'b0, 0, 1};
    vecs[6] = '{8'h01, 1'b1, 1, 0};

    reset = 1'b1;
    rxd = 1'b1;
    q_ready = 1'b0;
    overrun_clr = 1'b0;
    waitCycles(3);
    reset = 1'b0;
    waitCycles(2);

    checkOutput("reset_q_valid", {31'h0, q_valid}, 0);
    checkOutput("reset_fill", {27'h0, fill}, 0);
    checkOutput("reset_framing_err", {31'h0, framing_err}, 0);
    checkOutput("reset_overrun", {31'h0, overrun}, 0);
    checkOutput("reset_q", {24'h0, q}, 0);

    for (int v = 0; v < 7; v++) begin
      feBefore = feCount;
      applyStimulus(vecs[v].data, vecs[v].stopBit, 0);
      if (vecs[v].expFill != 0) sb.push_back(vecs[v].data);
      checkOutput($sformatf("vec%0d_fill", v), {27'h0, fill}, vecs[v].expFill);
      checkOutput($sformatf("vec%0d_q_valid", v), {31'h0, q_valid}, (vecs[v].expFill != 0) ? 1 : 0);
      checkOutput($sformatf("vec%0d_fe", v), feCount - feBefore, vecs[v].expFe);
      drainAll($sformatf("vec%0d_data", v));
    end

    feBefore = feCount;
    rxd = 1'b0;
    waitCycles(HALF / 2);
    rxd = 1'b1;
    waitCycles(2 * CPB);
    checkOutput("glitch_fill", {27'h0, fill}, 0);
    checkOutput("glitch_fe", feCount - feBefore, 0);
    applyStimulus(8'h5A, 1'b1, 0);
    sb.push_back(8'h5A);
    drainAll("glitch_after");

    feBefore = feCount;
    applyStimulus(8'h3C, 1'b0, 20 * CPB);
    checkOutput("break_fe_count", feCount - feBefore, 1);
    checkOutput("break_fill", {27'h0, fill}, 0);
    applyStimulus(8'h11, 1'b1, 0);
    checkOutput("break_next_q", {24'h0, q}, 32'h11);
    sb.push_back(8'h11);
    drainAll("break_next");

    for (int i = 0; i <= DEPTH; i++) begin
      applyStimulus(8'(i), 1'b1, 0);
      if (i < DEPTH) sb.push_back(8'(i));
    end
    checkOutput("ovr_fill", {27'h0, fill}, DEPTH);
    checkOutput("ovr_flag", {31'h0, overrun}, 1);
    drainAll("ovr_drain");
    checkOutput("ovr_sticky", {31'h0, overrun}, 1);
    overrun_clr = 1'b1;
    waitCycles(1);
    overrun_clr = 1'b0;
    checkOutput("ovr_cleared", {31'h0, overrun}, 0);

    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(8'h20 + 8'(i), 1'b1, 0);
      sb.push_back(8'h20 + 8'(i));
    end
    checkOutput("fullpop_fill_before", {27'h0, fill}, DEPTH);
    expHead = sb.pop_front();
    sb.push_back(8'h77);
    fork
      applyStimulus(8'h77, 1'b1, 0);
      begin
        waitCycles(PUSH_EDGE - 1);
        checkOutput("fullpop_head", {24'h0, q}, {24'h0, expHead});
        q_ready = 1'b1;
        waitCycles(1);
        q_ready = 1'b0;
      end
    join
    checkOutput("fullpop_fill_after", {27'h0, fill}, DEPTH);
    checkOutput("fullpop_overrun", {31'h0, overrun}, 0);
    drainAll("fullpop_drain");

    fork
      applyStimulus(8'hFF, 1'b1, 0);
      begin
        waitCycles(5 * CPB + CPB / 2);
        reset = 1'b1;
        waitCycles(1);
        reset = 1'b0;
        checkOutput("midreset_fill", {27'h0, fill}, 0);
      end
    join
    applyStimulus(8'h42, 1'b1, 0);
    checkOutput("midreset_after_fill", {27'h0, fill}, 1);
    sb.push_back(8'h42);
    drainAll("midreset_data");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
